// File: rtl/svi_scan_pkg.sv
// Shared types for the interface-array scanner: array size, FSM states, vector type.
package svi_scan_pkg;
  localparam int SIZE = 8;

  typedef enum logic [1:0] {IDLE, SCAN, VALID} scan_state_t;

  typedef logic [SIZE-1:0] svi_vec_t;
endpackage

// File: rtl/svi_array_scanner_if.sv
// Common interface I: three scalar members filled by an upstream driver.
interface I;
  logic x;
  logic y;
  logic z;

  modport master (output x, output y, output z);
  modport slave  (input  x, input  y, input  z);
endinterface

// File: rtl/svi_array_scanner_flatten.sv
// Combinational flattening of an array of I into packed x/y/z vectors.
module svi_array_flatten #(
  parameter int unsigned N = 8
) (
  I.slave            u_I [N-1:0],
  output logic [N-1:0] flat_x,
  output logic [N-1:0] flat_y,
  output logic [N-1:0] flat_z
);
  // Constant genvar indexing keeps interface-array access static.
  for (genvar k = 0; k < N; k++) begin : g_flat
    assign flat_x[k] = u_I[k].x;
    assign flat_y[k] = u_I[k].y;
    assign flat_z[k] = u_I[k].z;
  end
endmodule

// File: rtl/svi_array_scanner.sv
// Walks an array of I one index per clock and presents a packed x/y/z snapshot
// with a z-ones count over valid/ready. Optional parity output: SVI_SCAN_PARITY_EN.
module svi_array_scanner
  import svi_scan_pkg::*;
#(
  parameter int unsigned N  = SIZE,
  parameter int unsigned CW = $clog2(N + 1)
) (
  input  logic          i_clk,
  input  logic          i_arst_n,
  I.slave               u_I [N-1:0],
  input  logic          i_start,
  input  logic          i_ready,
  output logic          o_busy,
  output logic          o_valid,
  output logic [N-1:0]  o_a,
  output logic [N-1:0]  o_b,
  output logic [N-1:0]  o_c,
`ifdef SVI_SCAN_PARITY_EN
  output logic          o_parity,
`endif
  output logic [CW-1:0] o_zcount
);
  localparam int unsigned IW = $clog2(N);

  logic [N-1:0] flat_x, flat_y, flat_z;

  svi_array_flatten #(.N(N)) u_flatten (
    .u_I    (u_I),
    .flat_x (flat_x),
    .flat_y (flat_y),
    .flat_z (flat_z)
  );

  scan_state_t   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_c_q, sh_c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d, b_q, b_d, c_q, c_d;
  logic [CW-1:0] zc_q, zc_d;
  logic          busy_q, busy_d, valid_q, valid_d;
`ifdef SVI_SCAN_PARITY_EN
  logic          sh_par_q, sh_par_d, par_q, par_d;
`endif

  // Next-state, shadow capture and output load.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sh_c_d  = sh_c_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    zc_d    = zc_q;
    busy_d  = busy_q;
    valid_d = valid_q;
`ifdef SVI_SCAN_PARITY_EN
    sh_par_d = sh_par_q;
    par_d    = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = SCAN;
          idx_d   = '0;
          sh_a_d  = '0;
          sh_b_d  = '0;
          sh_c_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
`ifdef SVI_SCAN_PARITY_EN
          sh_par_d = 1'b0;
`endif
        end
      end
      SCAN: begin
        sh_a_d[idx_q] = flat_x[idx_q];
        sh_b_d[idx_q] = flat_y[idx_q];
        sh_c_d[idx_q] = flat_z[idx_q];
        cnt_d         = cnt_q + CW'(flat_z[idx_q]);
`ifdef SVI_SCAN_PARITY_EN
        sh_par_d = sh_par_q ^ flat_x[idx_q] ^ flat_y[idx_q] ^ flat_z[idx_q];
`endif
        if (idx_q == IW'(N - 1)) begin
          // Final index: outputs take the shadow including this edge's bit.
          a_d     = sh_a_d;
          b_d     = sh_b_d;
          c_d     = sh_c_d;
          zc_d    = cnt_d;
          state_d = VALID;
          idx_d   = '0;
          busy_d  = 1'b0;
          valid_d = 1'b1;
`ifdef SVI_SCAN_PARITY_EN
          par_d = sh_par_d;
`endif
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      VALID: begin
        if (i_ready) begin
          valid_d = 1'b0;
          if (i_start) begin
            state_d = SCAN;
            idx_d   = '0;
            sh_a_d  = '0;
            sh_b_d  = '0;
            sh_c_d  = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
`ifdef SVI_SCAN_PARITY_EN
            sh_par_d = 1'b0;
`endif
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sh_c_q  <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      zc_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef SVI_SCAN_PARITY_EN
      sh_par_q <= 1'b0;
      par_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sh_c_q  <= sh_c_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      zc_q    <= zc_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
`ifdef SVI_SCAN_PARITY_EN
      sh_par_q <= sh_par_d;
      par_q    <= par_d;
`endif
    end
  end

  assign o_busy   = busy_q;
  assign o_valid  = valid_q;
  assign o_a      = a_q;
  assign o_b      = b_q;
  assign o_c      = c_q;
  assign o_zcount = zc_q;
`ifdef SVI_SCAN_PARITY_EN
  assign o_parity = par_q;
`endif
endmodule

// File: tb/tb_svi_array_scanner.sv
// Directed bench for svi_array_scanner with a result scoreboard.
module tb_svi_array_scanner;
  import svi_scan_pkg::*;

  localparam int unsigned N  = SIZE;
  localparam int unsigned CW = $clog2(N + 1);

  typedef struct packed {
    svi_vec_t      a;
    svi_vec_t      b;
    svi_vec_t      c;
    logic [CW-1:0] cnt;
    logic          par;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic          i_ready = 1'b0;
  logic          o_busy, o_valid;
  logic [N-1:0]  o_a, o_b, o_c;
  logic [CW-1:0] o_zcount;
`ifdef SVI_SCAN_PARITY_EN
  logic          o_parity;
`endif
  svi_vec_t      xv = '0, yv = '0, za = '0;

  int   n_assert = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t last;

  I u_if [N-1:0] ();

  for (genvar k = 0; k < N; k++) begin : g_drv
    assign u_if[k].x = xv[k];
    assign u_if[k].y = yv[k];
    assign u_if[k].z = za[k];
  end

  svi_array_scanner #(.N(N)) dut (
    .i_clk    (clk),
    .i_arst_n (rst_n),
    .u_I      (u_if),
    .i_start  (i_start),
    .i_ready  (i_ready),
    .o_busy   (o_busy),
    .o_valid  (o_valid),
    .o_a      (o_a),
    .o_b      (o_b),
    .o_c      (o_c),
`ifdef SVI_SCAN_PARITY_EN
    .o_parity (o_parity),
`endif
    .o_zcount (o_zcount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outputs(input string tag, input exp_t e);
    chk({tag, "_a"}, 32'(o_a), 32'(e.a));
    chk({tag, "_b"}, 32'(o_b), 32'(e.b));
    chk({tag, "_c"}, 32'(o_c), 32'(e.c));
    chk({tag, "_zcount"}, 32'(o_zcount), 32'(e.cnt));
`ifdef SVI_SCAN_PARITY_EN
    chk({tag, "_parity"}, 32'(o_parity), 32'(e.par));
`endif
  endtask

  // Start accepted at the next edge; index k sampled at edge k+1. z switches to zc after edge chg.
  task automatic do_scan(input string tag, input svi_vec_t xn, input svi_vec_t yn,
                         input svi_vec_t zn, input int chg, input svi_vec_t zc,
                         input logic spam);
    exp_t     e;
    svi_vec_t zexp;
    for (int k = 0; k < int'(N); k++)
      zexp[k] = (chg >= 0 && k + 1 > chg) ? zc[k] : zn[k];
    e.a   = xn;
    e.b   = yn;
    e.c   = zexp;
    e.cnt = CW'($countones(zexp));
    e.par = ^{xn, yn, zexp};
    sb.push_back(e);
    xv = xn; yv = yn; za = zn;
    i_start = 1'b1;
    tick();
    i_ready = 1'b0;
    i_start = spam;
    chk({tag, "_busy_e0"}, 32'(o_busy), 32'd1);
    chk({tag, "_valid_e0"}, 32'(o_valid), 32'd0);
    for (int ed = 1; ed <= int'(N); ed++) begin
      tick();
      if (ed == chg) za = zc;
      if (ed < int'(N)) begin
        chk($sformatf("%s_busy_e%0d", tag, ed), 32'(o_busy), 32'd1);
        chk($sformatf("%s_valid_e%0d", tag, ed), 32'(o_valid), 32'd0);
      end else begin
        chk({tag, "_busy_done"}, 32'(o_busy), 32'd0);
        chk({tag, "_valid_done"}, 32'(o_valid), 32'd1);
      end
    end
    i_start = 1'b0;
    n_assert++;
    assert (sb.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
    end
    if (sb.size() != 0) begin
      last = sb.pop_front();
      chk_outputs(tag, last);
    end
  endtask

  task automatic ack(input string tag);
    i_ready = 1'b1;
    i_start = 1'b0;
    tick();
    i_ready = 1'b0;
    chk({tag, "_ack_valid"}, 32'(o_valid), 32'd0);
    chk({tag, "_ack_busy"}, 32'(o_busy), 32'd0);
    chk_outputs({tag, "_ack_hold"}, last);
  endtask

  initial begin
    exp_t zero_e;
    zero_e = '0;
    last   = '0;
    #12;
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk_outputs("rst", zero_e);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_valid", 32'(o_valid), 32'd0);

    do_scan("all_z1", 8'h00, 8'hFF, 8'hFF, -1, 8'h00, 1'b0);
    ack("all_z1");
    do_scan("all_z0", 8'h00, 8'hFF, 8'h00, -1, 8'h00, 1'b0);
    ack("all_z0");
    do_scan("toggle", 8'h00, 8'hFF, 8'hFF, 4, 8'h00, 1'b0);

    // Stall with i_start alone: result must hold.
    for (int c = 0; c < 5; c++) begin
      i_ready = 1'b0;
      i_start = (c % 2 == 0);
      tick();
      chk($sformatf("stall_valid_%0d", c), 32'(o_valid), 32'd1);
      chk($sformatf("stall_busy_%0d", c), 32'(o_busy), 32'd0);
      chk_outputs($sformatf("stall_%0d", c), last);
    end

    // Back-to-back: accept and restart on the same edge, start held high during scan.
    i_ready = 1'b1;
    do_scan("b2b", 8'hA5, 8'h3C, 8'h96, -1, 8'h00, 1'b1);
    ack("b2b");

    // Reset in the middle of a scan.
    xv = 8'hFF; yv = 8'hFF; za = 8'hFF;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    tick(); tick(); tick();
    chk("mid_busy", 32'(o_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(o_busy), 32'd0);
    chk("mid_rst_valid", 32'(o_valid), 32'd0);
    chk_outputs("mid_rst", zero_e);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      tick();
      chk($sformatf("post_rst_valid_%0d", c), 32'(o_valid), 32'd0);
      chk($sformatf("post_rst_busy_%0d", c), 32'(o_busy), 32'd0);
    end

    do_scan("after_rst", 8'h5A, 8'h01, 8'h81, -1, 8'h00, 1'b0);
    ack("after_rst");

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
